fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage; drives the IF/ID pipeline register (pc_in, instruction_in, write).
//  Holds the PC, issues one-outstanding requests to instruction memory and presents each fetched word.
//  Honours the hazard stall and branch/jump redirects from the execute stage.
//  Multicycle fetch: one instruction per three cycles at best (REQ -> WAIT -> PRESENT).
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  PC_STEP    4              byte increment between sequential fetches
//  NOP_INSN   32'h0000_0013  bubble word (addi x0,x0,0) shown on ifid_insn after reset
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  stall        in   1   hazard unit: hold the current instruction, do not write IF/ID
//  redirect     in   1   taken branch/jump: discard the in-flight or held fetch
//  redirect_pc  in   32  redirect target; bits [1:0] forced to 0
//  imem_req     out  1   fetch request; always accepted by memory in the cycle it is high
//  imem_addr    out  32  fetch address; valid while imem_req=1
//  imem_rvalid  in   1   read data valid (latency >=1 cycle after imem_req)
//  imem_rdata   in   32  instruction word
//  ifid_pc      out  32  PC of the presented instruction -> IF/ID pc_in
//  ifid_insn    out  32  presented instruction -> IF/ID instruction_in
//  ifid_write   out  1   IF/ID write enable
// BEHAVIOUR
//  Reset: state=REQ, pc=RESET_PC, kill=0, ifid_pc=0, ifid_insn=NOP_INSN; ifid_write=0, imem_req=0 while reset=1.
//  Reset mid-operation discards everything. imem shares reset, so no stale responses.
//  REQ: imem_req=1, imem_addr=pc -> WAIT. If redirect: pc<=redirect_pc, kill<=1 (old request still issued).
//  WAIT: imem_req=0. On rvalid:
//   - kill=1 or redirect=1: drop word, kill<=0, pc<=redirect_pc if redirect -> REQ.
//   - else ifid_pc<=pc, ifid_insn<=imem_rdata -> PRESENT.
//   Without rvalid: redirect sets pc<=redirect_pc, kill<=1; stay in WAIT.
//  PRESENT: ifid_write = ~stall & ~redirect (combinational, same cycle).
//   - redirect: pc<=redirect_pc -> REQ (instruction not written; redirect beats stall).
//   - stall, no redirect: stay; ifid_pc/ifid_insn held, no imem_req.
//   - neither: pc<=pc+PC_STEP (mod 2^32; 32'hFFFF_FFFC -> 0) -> REQ.
//  imem_rvalid outside WAIT is ignored. At most one request outstanding.
//  ifid_pc/ifid_insn are registered and change only when entering PRESENT (or on reset).
//  ifid_write is high for exactly one cycle per accepted instruction; never high outside PRESENT.
//  State encoding: 2 bits (REQ, WAIT, PRESENT); the unused code recovers to REQ.
// TESTING
//  1 Reset release, latency 1, rdata=0x00500093 -> c1 req addr 0; c2 rvalid; c3 write=1 pc=0 insn=0x00500093; c4 req addr 4.
//  2 stall=1 for 3 cycles in PRESENT (pc=8) -> write=0 and no req for 3 cycles, outputs held; write=1 once stall drops; next req addr 0xC.
//  3 redirect to 0x100 in WAIT, rvalid 2 cycles later (0xDEADBEEF) -> word dropped, no write; next req addr 0x100.
//  4 redirect=1 and stall=1 together in PRESENT, redirect_pc=0x203 -> write=0; next req addr 0x200.
//  5 redirect to 0xFFFF_FFFC, fetch completes and is written -> next req addr 0x0000_0000.
//  6 reset=1 in WAIT with rvalid=1 -> write=0, ifid_insn=NOP_INSN, ifid_pc=0; after release first req addr RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and IF/ID bus bundle for the fetch stage
interface fetch_unit_if;
    // Instruction-memory request/response
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // IF/ID pipeline register write port
    logic [31:0] ifid_pc;
    logic [31:0] ifid_insn;
    logic        ifid_write;

    // Fetch stage side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        output ifid_pc,
        output ifid_insn,
        output ifid_write
    );

    // Memory / pipeline-register side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        input  ifid_pc,
        input  ifid_insn,
        input  ifid_write
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multicycle instruction fetch stage (REQ -> WAIT -> PRESENT)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_insn_q;
    logic [31:0] target;

    // Redirect targets are always word aligned
    assign target = {redirect_pc[31:2], 2'b00};

    // Request is issued for exactly the one cycle spent in REQ
    assign bus.imem_req  = (state == S_REQ) && !reset;
    assign bus.imem_addr = pc;

    // IF/ID write only while presenting and neither held nor flushed
    assign bus.ifid_write = (state == S_PRESENT) && !stall && !redirect && !reset;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_insn  = ifid_insn_q;

    // Fetch FSM: PC tracking, stale-response kill flag and the presented instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            ifid_pc_q   <= 32'h0000_0000;
            ifid_insn_q <= NOP_INSN;
        end else begin
            case (state)
                S_REQ: begin
                    // The request for the old pc still goes out; its data gets killed
                    if (redirect) begin
                        pc   <= target;
                        kill <= 1'b1;
                    end
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (kill || redirect) begin
                            kill <= 1'b0;
                            if (redirect) begin
                                pc <= target;
                            end
                            state <= S_REQ;
                        end else begin
                            ifid_pc_q   <= pc;
                            ifid_insn_q <= bus.imem_rdata;
                            state       <= S_PRESENT;
                        end
                    end else if (redirect) begin
                        pc   <= target;
                        kill <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= S_REQ;
                    end else if (!stall) begin
                        pc    <= pc + 32'(PC_STEP);
                        state <= S_REQ;
                    end
                end
                default: begin
                    kill  <= 1'b0;
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    int          total = 0;
    int          bad = 0;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Inputs change just after a negedge; outputs sampled 1ns later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        next_cycle();
        next_cycle();
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
        total++; if (bus.ifid_write !== 1'b0) begin bad++; $display("FAIL reset_write got %b want 0", bus.ifid_write); end
        total++; if (bus.ifid_insn !== NOP) begin bad++; $display("FAIL reset_insn got %h want %h", bus.ifid_insn, NOP); end
        total++; if (bus.ifid_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want 0", bus.ifid_pc); end
    endtask

    task automatic test_first_fetch();
        next_cycle();
        reset = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL c1_req got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL c2_req got %b want 0", bus.imem_req); end
        total++; if (bus.ifid_write !== 1'b0) begin bad++; $display("FAIL c2_write got %b want 0", bus.ifid_write); end
        next_cycle();
        bus.imem_rvalid = 1'b0;
        #1;
        total++; if (bus.ifid_write !== 1'b1) begin bad++; $display("FAIL c3_write got %b want 1", bus.ifid_write); end
        total++; if (bus.ifid_pc !== 32'h0) begin bad++; $display("FAIL c3_pc got %h want 0", bus.ifid_pc); end
        total++; if (bus.ifid_insn !== 32'h0050_0093) begin bad++; $display("FAIL c3_insn got %h want 00500093", bus.ifid_insn); end
        next_cycle();
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin bad++; $display("FAIL c4_req got req=%b addr=%h want req=1 addr=4", bus.imem_req, bus.imem_addr); end
        // Complete the fetch at 4 with latency 2
        next_cycle();
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0010_0113;
        next_cycle();
        bus.imem_rvalid = 1'b0;
        #1;
        total++; if (bus.ifid_write !== 1'b1 || bus.ifid_pc !== 32'h4) begin bad++; $display("FAIL second_fetch got write=%b pc=%h want write=1 pc=4", bus.ifid_write, bus.ifid_pc); end
    endtask

    task automatic test_stall();
        next_cycle();
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin bad++; $display("FAIL stall_pre_req got req=%b addr=%h want req=1 addr=8", bus.imem_req, bus.imem_addr); end
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0020_8193;
        next_cycle();
        bus.imem_rvalid = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.ifid_write !== 1'b0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got write=%b req=%b want 0 0", i, bus.ifid_write, bus.imem_req); end
            total++; if (bus.ifid_pc !== 32'h8 || bus.ifid_insn !== 32'h0020_8193) begin bad++; $display("FAIL stall_regs%0d got pc=%h insn=%h want 8 00208193", i, bus.ifid_pc, bus.ifid_insn); end
            // rvalid outside WAIT must be ignored
            bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
            next_cycle();
            bus.imem_rvalid = 1'b0;
        end
        stall = 1'b0;
        #1;
        total++; if (bus.ifid_write !== 1'b1 || bus.ifid_insn !== 32'h0020_8193) begin bad++; $display("FAIL stall_release got write=%b insn=%h want 1 00208193", bus.ifid_write, bus.ifid_insn); end
        next_cycle();
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin bad++; $display("FAIL stall_next_req got req=%b addr=%h want req=1 addr=c", bus.imem_req, bus.imem_addr); end
        total++; if (bus.ifid_write !== 1'b0) begin bad++; $display("FAIL stall_single_write got %b want 0", bus.ifid_write); end
    endtask

    task automatic test_redirect_wait();
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h100;
        next_cycle();
        redirect = 1'b0;
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (bus.ifid_write !== 1'b0) begin bad++; $display("FAIL kill_write got %b want 0", bus.ifid_write); end
        next_cycle();
        bus.imem_rvalid = 1'b0;
        #1;
        total++; if (bus.ifid_write !== 1'b0 || bus.ifid_pc !== 32'h8) begin bad++; $display("FAIL kill_dropped got write=%b pc=%h want 0 8", bus.ifid_write, bus.ifid_pc); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("FAIL kill_next_req got req=%b addr=%h want req=1 addr=100", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_beats_stall();
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0113;
        next_cycle();
        bus.imem_rvalid = 1'b0;
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h203;
        #1;
        total++; if (bus.ifid_write !== 1'b0) begin bad++; $display("FAIL rs_write got %b want 0", bus.ifid_write); end
        total++; if (bus.ifid_pc !== 32'h100) begin bad++; $display("FAIL rs_pc got %h want 100", bus.ifid_pc); end
        next_cycle();
        redirect = 1'b0; stall = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin bad++; $display("FAIL rs_next_req got req=%b addr=%h want req=1 addr=200", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_wrap();
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect = 1'b0;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1234_5678;
        next_cycle();
        bus.imem_rvalid = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got req=%b addr=%h want req=1 addr=fffffffc", bus.imem_req, bus.imem_addr); end
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0513;
        next_cycle();
        bus.imem_rvalid = 1'b0;
        #1;
        total++; if (bus.ifid_write !== 1'b1 || bus.ifid_pc !== 32'hFFFF_FFFC || bus.ifid_insn !== 32'h0000_0513) begin bad++; $display("FAIL wrap_present got write=%b pc=%h insn=%h want 1 fffffffc 00000513", bus.ifid_write, bus.ifid_pc, bus.ifid_insn); end
        next_cycle();
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_req got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        next_cycle();
        reset = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
        #1;
        total++; if (bus.ifid_write !== 1'b0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_wait_out got write=%b req=%b want 0 0", bus.ifid_write, bus.imem_req); end
        next_cycle();
        bus.imem_rvalid = 1'b0;
        #1;
        total++; if (bus.ifid_insn !== NOP || bus.ifid_pc !== 32'h0) begin bad++; $display("FAIL rst_wait_regs got pc=%h insn=%h want 0 %h", bus.ifid_pc, bus.ifid_insn, NOP); end
        total++; if (bus.ifid_write !== 1'b0) begin bad++; $display("FAIL rst_wait_write got %b want 0", bus.ifid_write); end
        next_cycle();
        reset = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_wait_req got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_beats_stall();
        test_wrap();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
